// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 4-stage RV32I pipeline.
// Tracks EX/MEM destinations, drives forwarding selects, load-use stalls and flush bubbles.
module hazard_ctrl #(
    parameter int NB_OPERAND = 5,
    parameter int NB_CNT     = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_id_valid,
    input  logic [NB_OPERAND-1:0] i_id_rs1,
    input  logic [NB_OPERAND-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic [NB_OPERAND-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_is_load,
    input  logic                  i_flush,
    output logic [1:0]            o_fwd_rs1,
    output logic [1:0]            o_fwd_rs2,
    output logic                  o_stall,
    output logic                  o_bubble,
    output logic [NB_CNT-1:0]     o_stall_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [NB_OPERAND-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } ex_slot_t;

    // At writeback a load and an ALU result look identical, so MEM drops is_load.
    typedef struct packed {
        logic                  valid;
        logic [NB_OPERAND-1:0] rd;
        logic                  reg_write;
    } mem_slot_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    ex_slot_t          r_ex;
    mem_slot_t         r_mem;
    logic [NB_CNT-1:0] r_stall_cnt;

    ex_slot_t w_id_slot;
    logic     w_ex_live;
    logic     w_mem_live;
    logic     w_rs1_load_hit;
    logic     w_rs2_load_hit;
    logic     w_stall;
    logic     w_bubble;

    assign w_id_slot  = {i_id_valid, i_id_rd, i_id_reg_write, i_id_is_load};
    assign w_ex_live  = r_ex.valid & r_ex.reg_write & (r_ex.rd != '0);
    assign w_mem_live = r_mem.valid & r_mem.reg_write & (r_mem.rd != '0);

    function automatic logic [1:0] fwd_sel(
        input logic                  id_valid,
        input logic                  use_s,
        input logic [NB_OPERAND-1:0] rs,
        input logic                  ex_live,
        input ex_slot_t              ex,
        input logic                  mem_live,
        input mem_slot_t             mem
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (id_valid && use_s && (rs != '0)) begin
            // EX is checked first so the youngest producer wins.
            if (ex_live && (ex.rd == rs) && !ex.is_load)
                sel = FWD_EX;
            else if (mem_live && (mem.rd == rs))
                sel = FWD_MEM;
        end
        return sel;
    endfunction

    assign o_fwd_rs1 = fwd_sel(i_id_valid, i_id_use_rs1, i_id_rs1,
                               w_ex_live, r_ex, w_mem_live, r_mem);
    assign o_fwd_rs2 = fwd_sel(i_id_valid, i_id_use_rs2, i_id_rs2,
                               w_ex_live, r_ex, w_mem_live, r_mem);

    assign w_rs1_load_hit = i_id_use_rs1 & (i_id_rs1 != '0) & (r_ex.rd == i_id_rs1);
    assign w_rs2_load_hit = i_id_use_rs2 & (i_id_rs2 != '0) & (r_ex.rd == i_id_rs2);

    // A flush kills the dependent instruction, so it overrides the load-use stall.
    assign w_stall  = i_id_valid & ~i_flush & w_ex_live & r_ex.is_load
                    & (w_rs1_load_hit | w_rs2_load_hit);
    assign w_bubble = w_stall | i_flush;

    assign o_stall     = w_stall;
    assign o_bubble    = w_bubble;
    assign o_stall_cnt = r_stall_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flops.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_mem <= {r_ex.valid, r_ex.rd, r_ex.reg_write};
            r_ex  <= w_bubble ? '0 : w_id_slot;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the 4-stage RV32I pipeline (IF, ID, EX, MEM/WB). It tracks the destination registers of the instructions in EX and MEM in its own in-flight scoreboard. From that it drives the forwarding selects consumed by the decode stage, and stalls ID/IF for one cycle on a load-use hazard. It also inserts bubbles on a branch/jump flush and counts stall cycles for performance monitoring.

## Interface
- NB_OPERAND, 5, register address width
- NB_CNT, 16, stall-counter width
- i_clock  in  1  pipeline clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_id_valid  in  1  ID holds a valid instruction
- i_id_rs1  in  NB_OPERAND  ID source register 1
- i_id_rs2  in  NB_OPERAND  ID source register 2
- i_id_use_rs1  in  1  ID instruction reads rs1
- i_id_use_rs2  in  1  ID instruction reads rs2
- i_id_rd  in  NB_OPERAND  ID destination register
- i_id_reg_write  in  1  ID instruction writes rd (includes JAL/JALR return address)
- i_id_is_load  in  1  ID instruction is a LOAD
- i_flush  in  1  taken branch/jump resolved in EX; kill ID instruction
- o_fwd_rs1  out  2  00 = RF, 01 = ALU result (EX), 10 = MEM result
- o_fwd_rs2  out  2  same encoding for rs2
- o_stall  out  1  hold PC and IF/ID register this cycle
- o_bubble  out  1  ID instruction does not advance; EX receives a NOP
- o_stall_cnt  out  NB_CNT  saturating count of stall cycles

## Operation
- Scoreboard has two slots, EX and MEM. Each slot holds {valid, rd, reg_write, is_load}.
- Slot is "live" when valid=1, reg_write=1 and rd!=0.
- Advance on every rising edge:
  - MEM <= EX.
  - EX <= {i_id_valid, i_id_rd, i_id_reg_write, i_id_is_load} when advancing.
  - EX <= all-zero when o_bubble=1.
- o_bubble = o_stall | i_flush.
- Forward select, per source s in {rs1, rs2}. Select is 00 if use_s=0, rs_s=0 or i_id_valid=0. Otherwise, first match wins:
  - EX live and EX.rd==rs_s and EX.is_load=0 -> 01.
  - MEM live and MEM.rd==rs_s -> 10 (MEM result is the writeback value, load or ALU).
  - Else -> 00. RF was written at the end of that instruction's MEM cycle.
- Load-use: stall = i_id_valid & !i_flush & EX live & EX.is_load & ((use_rs1 & rs1!=0 & EX.rd==rs1) | (use_rs2 & rs2!=0 & EX.rd==rs2)).
- During stall, forward selects are still computed but are don't-care. ID re-evaluates next cycle, when the load sits in MEM -> select 10.
- EX priority over MEM gives the youngest producer when both match.
- Flush and stall in the same cycle: flush wins. o_stall=0, o_bubble=1, EX slot cleared, stall counter not incremented.
- A flush does not clear the MEM slot; the instruction in EX (the branch itself) still retires.
- o_stall_cnt increments by 1 each cycle o_stall=1 and saturates at all-ones.

## Timing
- o_fwd_rs1, o_fwd_rs2, o_stall and o_bubble are combinational from the slot registers and same-cycle ID inputs. There is no register in the path to the idecode mux.
- Scoreboard and counter update on the rising i_clock edge only.
- Load-use penalty is exactly 1 cycle. Back-to-back dependent ALU ops: 0 cycles.
- Asynchronous reset (i_reset_n=0), effective immediately and independent of the clock:
  - Both slots cleared to all-zero.
  - o_stall_cnt=0.
  - Outputs become fwd=00, stall=0, bubble=i_flush.
- Reset mid-stall discards the pending load; after release, ID is evaluated against empty slots.
- Deassertion is synchronous to i_clock via the upstream reset synchronizer; no internal synchronizer.

## Test plan
- Reset: hold i_reset_n=0 with random ID inputs -> fwd=00/00, stall=0, stall_cnt=0. Scoreboard stays empty for 1 cycle after release.
- ALU-ALU: ADD x5 issued, next cycle ID reads rs1=x5 -> o_fwd_rs1=01, no stall. One cycle later, the same read -> 10. Two cycles later -> 00.
- Load-use: LW x7 issued, next ID reads rs2=x7 -> stall=1, bubble=1 for 1 cycle, stall_cnt=1. Next cycle -> stall=0, o_fwd_rs2=10.
- Priority and x0:
  - EX and MEM both write x3, ID reads x3 -> 01.
  - EX writes rd=0, ID reads x0 -> 00.
  - use_rs1=0 with a matching rs1 -> 00.
- Flush: LW x9 in EX, ID reads x9, i_flush=1 -> stall=0, bubble=1, stall_cnt unchanged. Next cycle the EX slot is empty and the MEM slot holds x9.
- Counter saturation: NB_CNT=4, force 20 consecutive load-use stalls -> o_stall_cnt stops at 15.
